hero_burst_rx: RTL and testbench



---
 rtl/hero_burst_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_hero_burst_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hero_burst_rx.sv
// Receive end of the hero write bus: assembles VALID beats into bursts closed by DONE
// and queues completed bursts in a first-word fall-through FIFO with a valid/ready head.

module hero_burst_rx_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic [CW-1:0] count
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(DEPTH))));

endmodule

module hero_burst_rx #(
  parameter int HERO_WIDTH = 32,
  parameter int MAX_BEATS  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        hero_cycle,
  input  logic [HERO_WIDTH-1:0]             hero_data,
  output logic                              hero_stall,
  output logic                              burst_valid,
  input  logic                              burst_ready,
  output logic [MAX_BEATS*HERO_WIDTH-1:0]   burst_data,
  output logic [$clog2(MAX_BEATS+1)-1:0]    burst_len,
  output logic                              burst_err,
  output logic                              proto_err
);

  localparam int LW = $clog2(MAX_BEATS + 1);
  localparam int BW = MAX_BEATS * HERO_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] CYC_IDLE  = 2'd0;
  localparam logic [1:0] CYC_VALID = 2'd1;
  localparam logic [1:0] CYC_DONE  = 2'd2;
  localparam logic [1:0] CYC_RSV   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e          state_r, state_nxt_s;
  logic [BW-1:0]   buf_r, buf_nxt_s;
  logic [LW-1:0]   cnt_r, cnt_nxt_s;
  logic            push_s;
  logic [LW-1:0]   push_len_s;
  logic            push_err_s;
  logic            perr_s;
  logic            take_s;

  logic [BW-1:0]   mem_data_r [DEPTH];
  logic [LW-1:0]   mem_len_r  [DEPTH];
  logic            mem_err_r  [DEPTH];
  logic [PW-1:0]   wptr_r, rptr_r, rptr_nxt_s;
  logic [CW-1:0]   count_r, count_nxt_s;
  logic            pop_s;

  logic            stall_r;
  logic            perr_r;
  logic            valid_r;
  logic [BW-1:0]   head_data_r, head_data_nxt_s;
  logic [LW-1:0]   head_len_r, head_len_nxt_s;
  logic            head_err_r, head_err_nxt_s;

  // Only cycles seen while not stalled are consumed; the transmitter holds the rest.
  assign take_s = !stall_r;
  assign pop_s  = valid_r & burst_ready;

  // Burst assembly: next state, buffer update and FIFO push request.
  always_comb begin
    state_nxt_s = state_r;
    buf_nxt_s   = buf_r;
    cnt_nxt_s   = cnt_r;
    push_s      = 1'b0;
    push_len_s  = cnt_r;
    push_err_s  = 1'b0;
    perr_s      = 1'b0;
    if (take_s) begin
      case (state_r)
        S_IDLE: begin
          case (hero_cycle)
            CYC_VALID: begin
              buf_nxt_s   = BW'(hero_data);
              cnt_nxt_s   = LW'(1);
              state_nxt_s = S_COLLECT;
            end
            CYC_DONE: perr_s = 1'b1;
            CYC_RSV:  perr_s = 1'b1;
            default:  perr_s = 1'b0;
          endcase
        end
        S_COLLECT: begin
          case (hero_cycle)
            CYC_VALID: begin
              if (cnt_r < LW'(MAX_BEATS)) begin
                for (int i = 0; i < MAX_BEATS; i++) begin
                  if (cnt_r == LW'(i)) begin
                    buf_nxt_s[i*HERO_WIDTH +: HERO_WIDTH] = hero_data;
                  end else begin
                    buf_nxt_s[i*HERO_WIDTH +: HERO_WIDTH] = buf_r[i*HERO_WIDTH +: HERO_WIDTH];
                  end
                end
                cnt_nxt_s = cnt_r + LW'(1);
              end else begin
                state_nxt_s = S_DISCARD;
              end
            end
            CYC_DONE: begin
              push_s      = 1'b1;
              push_len_s  = cnt_r;
              push_err_s  = 1'b0;
              buf_nxt_s   = {BW{1'b0}};
              cnt_nxt_s   = {LW{1'b0}};
              state_nxt_s = S_IDLE;
            end
            CYC_RSV: perr_s = 1'b1;
            default: perr_s = 1'b0;
          endcase
        end
        S_DISCARD: begin
          case (hero_cycle)
            CYC_DONE: begin
              push_s      = 1'b1;
              push_len_s  = LW'(MAX_BEATS);
              push_err_s  = 1'b1;
              buf_nxt_s   = {BW{1'b0}};
              cnt_nxt_s   = {LW{1'b0}};
              state_nxt_s = S_IDLE;
            end
            CYC_RSV: perr_s = 1'b1;
            default: perr_s = 1'b0;
          endcase
        end
        default: begin
          state_nxt_s = S_IDLE;
          buf_nxt_s   = {BW{1'b0}};
          cnt_nxt_s   = {LW{1'b0}};
        end
      endcase
    end else begin
      perr_s = 1'b0;
    end
  end

  // Assembly state, buffer and beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      buf_r   <= {BW{1'b0}};
      cnt_r   <= {LW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      buf_r   <= buf_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // FIFO bookkeeping and the head entry that becomes visible after the edge.
  always_comb begin
    count_nxt_s     = count_r + CW'(push_s) - CW'(pop_s);
    rptr_nxt_s      = rptr_r;
    head_data_nxt_s = {BW{1'b0}};
    head_len_nxt_s  = {LW{1'b0}};
    head_err_nxt_s  = 1'b0;
    if (pop_s) begin
      rptr_nxt_s = rptr_r + PW'(1);
    end else begin
      rptr_nxt_s = rptr_r;
    end
    // A push landing on the new read slot must bypass storage to keep fall-through.
    if (count_nxt_s == {CW{1'b0}}) begin
      head_data_nxt_s = {BW{1'b0}};
      head_len_nxt_s  = {LW{1'b0}};
      head_err_nxt_s  = 1'b0;
    end else if (push_s && (wptr_r == rptr_nxt_s)) begin
      head_data_nxt_s = buf_r;
      head_len_nxt_s  = push_len_s;
      head_err_nxt_s  = push_err_s;
    end else begin
      head_data_nxt_s = mem_data_r[rptr_nxt_s];
      head_len_nxt_s  = mem_len_r[rptr_nxt_s];
      head_err_nxt_s  = mem_err_r[rptr_nxt_s];
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= {BW{1'b0}};
        mem_len_r[i]  <= {LW{1'b0}};
        mem_err_r[i]  <= 1'b0;
      end
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_data_r[wptr_r] <= buf_r;
        mem_len_r[wptr_r]  <= push_len_s;
        mem_err_r[wptr_r]  <= push_err_s;
        wptr_r             <= wptr_r + PW'(1);
      end
      rptr_r  <= rptr_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Registered outputs: stall, protocol pulse and the presented head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r     <= 1'b0;
      perr_r      <= 1'b0;
      valid_r     <= 1'b0;
      head_data_r <= {BW{1'b0}};
      head_len_r  <= {LW{1'b0}};
      head_err_r  <= 1'b0;
    end else begin
      stall_r     <= (count_nxt_s == CW'(DEPTH));
      perr_r      <= perr_s;
      valid_r     <= (count_nxt_s != {CW{1'b0}});
      head_data_r <= head_data_nxt_s;
      head_len_r  <= head_len_nxt_s;
      head_err_r  <= head_err_nxt_s;
    end
  end

  assign hero_stall  = stall_r;
  assign proto_err   = perr_r;
  assign burst_valid = valid_r;
  assign burst_data  = head_data_r;
  assign burst_len   = head_len_r;
  assign burst_err   = head_err_r;

  hero_burst_rx_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .count (count_r)
  );

endmodule

// File: tb/tb_hero_burst_rx.sv
// Self-checking bench for hero_burst_rx: directed scenarios plus randomized traffic
// checked against a queue-based burst model.

module tb_hero_burst_rx;

  localparam int W  = 32;
  localparam int MB = 8;
  localparam int DP = 4;
  localparam int LW = $clog2(MB + 1);
  localparam int BW = MB * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    hero_cycle = 2'd0;
  logic [W-1:0]  hero_data = '0;
  logic          hero_stall;
  logic          burst_valid;
  logic          burst_ready = 1'b0;
  logic [BW-1:0] burst_data;
  logic [LW-1:0] burst_len;
  logic          burst_err;
  logic          proto_err;

  typedef struct {
    logic [BW-1:0] data;
    int            len;
    logic          err;
  } burst_t;

  burst_t     exp_q[$];
  logic [W-1:0] m_beats[$];
  bit         m_in, m_over, m_stall, m_perr;
  int         n_checks = 0;
  int         n_fail = 0;

  hero_burst_rx #(.HERO_WIDTH(W), .MAX_BEATS(MB), .DEPTH(DP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hero_cycle  (hero_cycle),
    .hero_data   (hero_data),
    .hero_stall  (hero_stall),
    .burst_valid (burst_valid),
    .burst_ready (burst_ready),
    .burst_data  (burst_data),
    .burst_len   (burst_len),
    .burst_err   (burst_err),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_beats.delete();
    m_in = 0; m_over = 0; m_stall = 0; m_perr = 0;
  endtask

  // Drive one bus cycle, advance the model across the edge, return 1 time unit after it.
  task automatic step(input logic [1:0] cyc, input logic [W-1:0] d, input logic rdy);
    burst_t b;
    bit acc;
    hero_cycle = cyc; hero_data = d; burst_ready = rdy;
    @(posedge clk);
    acc = !m_stall;
    m_perr = 0;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (acc) begin
      case (cyc)
        2'd1: begin
          if (!m_in) begin m_beats.delete(); m_beats.push_back(d); m_in = 1; end
          else if (m_beats.size() < MB) m_beats.push_back(d);
          else m_over = 1;
        end
        2'd2: begin
          if (!m_in) m_perr = 1;
          else begin
            b.data = '0;
            foreach (m_beats[i]) b.data[i*W +: W] = m_beats[i];
            b.len = m_beats.size();
            b.err = m_over;
            exp_q.push_back(b);
            m_in = 0; m_over = 0; m_beats.delete();
          end
        end
        2'd3: m_perr = 1;
        default: ;
      endcase
    end
    m_stall = (exp_q.size() == DP);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (burst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", burst_valid); end
    n_checks++; if (hero_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%0b exp=0", hero_stall); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr got=%0b exp=0", proto_err); end
    n_checks++; if (burst_len !== '0) begin n_fail++; $display("FAIL rst_len got=%0d exp=0", burst_len); end
    n_checks++; if (burst_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", burst_err); end
    n_checks++; if (burst_data !== '0) begin n_fail++; $display("FAIL rst_data got=%0h exp=0", burst_data); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [BW-1:0] exp_d;
    exp_d = '0;
    exp_d[0*W +: W] = 32'hA0; exp_d[1*W +: W] = 32'hA1; exp_d[2*W +: W] = 32'hA2;
    step(2'd1, 32'hA0, 1'b1);
    step(2'd1, 32'hA1, 1'b1);
    step(2'd1, 32'hA2, 1'b1);
    step(2'd2, 32'h0, 1'b1);
    n_checks++; if (burst_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0b exp=1", burst_valid); end
    n_checks++; if (burst_len !== LW'(3)) begin n_fail++; $display("FAIL basic_len got=%0d exp=3", burst_len); end
    n_checks++; if (burst_data !== exp_d) begin n_fail++; $display("FAIL basic_data got=%0h exp=%0h", burst_data, exp_d); end
    n_checks++; if (burst_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%0b exp=0", burst_err); end
    step(2'd0, 32'h0, 1'b1);
    n_checks++; if (burst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped got=%0b exp=0", burst_valid); end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] exp_d;
    exp_d = '0;
    for (int i = 0; i < MB; i++) exp_d[i*W +: W] = W'(i);
    for (int i = 0; i < 10; i++) begin
      step(2'd1, W'(i), 1'b1);
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL ovf_perr beat=%0d got=%0b exp=0", i, proto_err); end
    end
    step(2'd2, 32'h0, 1'b1);
    n_checks++; if (burst_len !== LW'(MB)) begin n_fail++; $display("FAIL ovf_len got=%0d exp=%0d", burst_len, MB); end
    n_checks++; if (burst_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%0b exp=1", burst_err); end
    n_checks++; if (burst_data !== exp_d) begin n_fail++; $display("FAIL ovf_data got=%0h exp=%0h", burst_data, exp_d); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL ovf_perr_done got=%0b exp=0", proto_err); end
    step(2'd0, 32'h0, 1'b1);
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      step(2'd1, 32'hB0 + W'(k), 1'b0);
      step(2'd2, 32'h0, 1'b0);
    end
    n_checks++; if (hero_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%0b exp=1", hero_stall); end
    for (int k = 0; k < 3; k++) begin
      step(2'd1, 32'hB4, 1'b0);
      n_checks++; if (hero_stall !== 1'b1) begin n_fail++; $display("FAIL full_held got=%0b exp=1", hero_stall); end
    end
    step(2'd1, 32'hB4, 1'b1);
    n_checks++; if (hero_stall !== 1'b0) begin n_fail++; $display("FAIL full_release got=%0b exp=0", hero_stall); end
    n_checks++; if (burst_data[W-1:0] !== 32'hB1) begin n_fail++; $display("FAIL full_head got=%0h exp=b1", burst_data[W-1:0]); end
    step(2'd1, 32'hB4, 1'b0);
    step(2'd2, 32'h0, 1'b0);
    n_checks++; if (hero_stall !== 1'b1) begin n_fail++; $display("FAIL full_again got=%0b exp=1", hero_stall); end
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (burst_valid !== 1'b1 || burst_data[W-1:0] !== 32'hB0 + W'(k) || burst_len !== LW'(1))
        begin n_fail++; $display("FAIL full_order k=%0d got=%0h/%0d exp=%0h/1", k, burst_data[W-1:0], burst_len, 32'hB0 + W'(k)); end
      step(2'd0, 32'h0, 1'b1);
    end
    n_checks++; if (burst_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained got=%0b exp=0", burst_valid); end
  endtask

  task automatic test_proto();
    logic [BW-1:0] exp_d;
    exp_d = '0;
    exp_d[0*W +: W] = 32'hC0; exp_d[1*W +: W] = 32'hC1;
    step(2'd2, 32'h0, 1'b1);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_done_idle got=%0b exp=1", proto_err); end
    step(2'd0, 32'h0, 1'b1);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_pulse_end got=%0b exp=0", proto_err); end
    step(2'd1, 32'hC0, 1'b1);
    step(2'd3, 32'hFF, 1'b1);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_rsv got=%0b exp=1", proto_err); end
    step(2'd1, 32'hC1, 1'b1);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_rsv_end got=%0b exp=0", proto_err); end
    step(2'd2, 32'h0, 1'b1);
    n_checks++; if (burst_len !== LW'(2) || burst_data !== exp_d)
      begin n_fail++; $display("FAIL proto_burst got=%0d/%0h exp=2/%0h", burst_len, burst_data, exp_d); end
    step(2'd0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp_a, exp_b;
    exp_a = '0; exp_a[0*W +: W] = 32'hD0; exp_a[1*W +: W] = 32'hD1;
    exp_b = '0; exp_b[0*W +: W] = 32'hD2;
    step(2'd1, 32'hD0, 1'b0);
    step(2'd1, 32'hD1, 1'b0);
    step(2'd2, 32'h0, 1'b0);
    step(2'd1, 32'hD2, 1'b0);
    step(2'd2, 32'h0, 1'b0);
    n_checks++; if (burst_len !== LW'(2) || burst_data !== exp_a)
      begin n_fail++; $display("FAIL b2b_first got=%0d/%0h exp=2/%0h", burst_len, burst_data, exp_a); end
    step(2'd0, 32'h0, 1'b1);
    n_checks++; if (burst_valid !== 1'b1 || burst_len !== LW'(1) || burst_data !== exp_b)
      begin n_fail++; $display("FAIL b2b_second got=%0b/%0d/%0h exp=1/1/%0h", burst_valid, burst_len, burst_data, exp_b); end
    step(2'd0, 32'h0, 1'b1);
    n_checks++; if (burst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%0b exp=0", burst_valid); end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] exp_d;
    exp_d = '0; exp_d[0*W +: W] = 32'hE3;
    step(2'd1, 32'hE0, 1'b0);
    step(2'd2, 32'h0, 1'b0);
    step(2'd1, 32'hE1, 1'b0);
    step(2'd1, 32'hE2, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++; if (burst_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%0b exp=0", burst_valid); end
    n_checks++; if (burst_data !== '0 || burst_len !== '0) begin n_fail++; $display("FAIL rmid_data got=%0h/%0d exp=0/0", burst_data, burst_len); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'd1, 32'hE3, 1'b1);
    step(2'd2, 32'h0, 1'b1);
    n_checks++; if (burst_valid !== 1'b1 || burst_len !== LW'(1) || burst_data !== exp_d)
      begin n_fail++; $display("FAIL rmid_new got=%0b/%0d/%0h exp=1/1/%0h", burst_valid, burst_len, burst_data, exp_d); end
    step(2'd0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic [BW-1:0] ed;
    int el, r;
    logic ee;
    logic [1:0] cyc;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(99);
      cyc = (r < 20) ? 2'd0 : (r < 75) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
      step(cyc, $urandom, ($urandom_range(99) < 60));
      if (exp_q.size() != 0) begin ed = exp_q[0].data; el = exp_q[0].len; ee = exp_q[0].err; end
      else begin ed = '0; el = 0; ee = 1'b0; end
      n_checks++; if (burst_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, burst_valid, exp_q.size() != 0); end
      n_checks++; if (hero_stall !== m_stall) begin n_fail++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, hero_stall, m_stall); end
      n_checks++; if (proto_err !== m_perr) begin n_fail++; $display("FAIL rnd_perr n=%0d got=%0b exp=%0b", n, proto_err, m_perr); end
      n_checks++; if (burst_data !== ed) begin n_fail++; $display("FAIL rnd_data n=%0d got=%0h exp=%0h", n, burst_data, ed); end
      n_checks++; if (burst_len !== LW'(el)) begin n_fail++; $display("FAIL rnd_len n=%0d got=%0d exp=%0d", n, burst_len, el); end
      n_checks++; if (burst_err !== ee) begin n_fail++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, burst_err, ee); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full();
    test_proto();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
